// File: rtl/if_id_pipeline_skid.sv
// IF/ID pipeline register: valid/ready handshake, 2-entry skid for back-pressure,
// synchronous flush on redirect, and registered decode of the held instruction.
module if_id_pipeline_skid #(
    parameter int unsigned    XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter logic [31:0]    NOP_INSTR = 32'h0000_0013,
    parameter bit             SKID_EN   = 1'b1
) (
    input  logic            Clk,
    input  logic            Reset_n,
    input  logic            In_Valid,
    output logic            In_Ready,
    input  logic [31:0]     Instruction_IF,
    input  logic [XLEN-1:0] PC_IF,
    input  logic            Flush,
    output logic            Out_Valid,
    input  logic            Out_Ready,
    output logic [31:0]     Instruction_ID,
    output logic [XLEN-1:0] PC_ID,
    output logic [4:0]      rs1_ID,
    output logic [4:0]      rs2_ID,
    output logic [4:0]      rd_ID,
    output logic [6:0]      Opcode_ID,
    output logic [2:0]      Func3_ID,
    output logic [6:0]      Func7_ID,
    output logic [1:0]      Occupancy
);

    localparam int unsigned ILEN  = 32;
    localparam int unsigned OCC_W = 2;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [ILEN-1:0]   instr_q, instr_d;
    logic [XLEN-1:0]   pc_q, pc_d;
    logic [ILEN-1:0]   skid_instr_q, skid_instr_d;
    logic [XLEN-1:0]   skid_pc_q, skid_pc_d;
    logic              out_valid_q, out_valid_d;
    logic              in_ready_q, in_ready_d;
    logic [OCC_W-1:0]  occ_q, occ_d;
    logic [4:0]        rs1_q, rs2_q, rd_q;
    logic [6:0]        opcode_q, func7_q;
    logic [2:0]        func3_q;
    logic              in_ready_c, in_fire_c, out_fire_c;

    // Without the skid entry, ready must see the decoder's consume in the same cycle.
    assign in_ready_c = SKID_EN ? in_ready_q : (!out_valid_q || Out_Ready);
    assign in_fire_c  = In_Valid && in_ready_c;
    assign out_fire_c = out_valid_q && Out_Ready;

    // Next-state: main register feeds the decoder, skid catches one overflow entry.
    always_comb begin
        state_d      = state_q;
        instr_d      = instr_q;
        pc_d         = pc_q;
        skid_instr_d = skid_instr_q;
        skid_pc_d    = skid_pc_q;
        occ_d        = OCC_W'(0);
        if (Flush) begin
            state_d = ST_EMPTY;
            instr_d = NOP_INSTR;
            pc_d    = RESET_PC;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (in_fire_c) begin
                        instr_d = Instruction_IF;
                        pc_d    = PC_IF;
                        state_d = ST_FULL;
                    end
                end
                ST_FULL: begin
                    if (in_fire_c && out_fire_c) begin
                        instr_d = Instruction_IF;
                        pc_d    = PC_IF;
                    end else if (in_fire_c && SKID_EN) begin
                        skid_instr_d = Instruction_IF;
                        skid_pc_d    = PC_IF;
                        state_d      = ST_SKID;
                    end else if (out_fire_c) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_SKID: begin
                    if (out_fire_c) begin
                        instr_d = skid_instr_q;
                        pc_d    = skid_pc_q;
                        state_d = ST_FULL;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
        case (state_d)
            ST_FULL: occ_d = OCC_W'(1);
            ST_SKID: occ_d = OCC_W'(2);
            default: occ_d = OCC_W'(0);
        endcase
        out_valid_d = (state_d != ST_EMPTY);
        in_ready_d  = (state_d != ST_SKID);
    end

    // Decode fields are taken from the next held word so they move in lockstep with it.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q      <= ST_EMPTY;
            instr_q      <= NOP_INSTR;
            pc_q         <= RESET_PC;
            skid_instr_q <= NOP_INSTR;
            skid_pc_q    <= RESET_PC;
            out_valid_q  <= 1'b0;
            in_ready_q   <= 1'b1;
            occ_q        <= OCC_W'(0);
            rs1_q        <= NOP_INSTR[19:15];
            rs2_q        <= NOP_INSTR[24:20];
            rd_q         <= NOP_INSTR[11:7];
            opcode_q     <= NOP_INSTR[6:0];
            func3_q      <= NOP_INSTR[14:12];
            func7_q      <= NOP_INSTR[31:25];
        end else begin
            state_q      <= state_d;
            instr_q      <= instr_d;
            pc_q         <= pc_d;
            skid_instr_q <= skid_instr_d;
            skid_pc_q    <= skid_pc_d;
            out_valid_q  <= out_valid_d;
            in_ready_q   <= in_ready_d;
            occ_q        <= occ_d;
            rs1_q        <= instr_d[19:15];
            rs2_q        <= instr_d[24:20];
            rd_q         <= instr_d[11:7];
            opcode_q     <= instr_d[6:0];
            func3_q      <= instr_d[14:12];
            func7_q      <= instr_d[31:25];
        end
    end

    assign In_Ready       = in_ready_c;
    assign Out_Valid      = out_valid_q;
    assign Instruction_ID = instr_q;
    assign PC_ID          = pc_q;
    assign rs1_ID         = rs1_q;
    assign rs2_ID         = rs2_q;
    assign rd_ID          = rd_q;
    assign Opcode_ID      = opcode_q;
    assign Func3_ID       = func3_q;
    assign Func7_ID       = func7_q;
    assign Occupancy      = occ_q;

endmodule

// File: tb/tb_if_id_pipeline_skid.sv
// Bench for if_id_pipeline_skid: directed scenarios plus randomized traffic
// against a FIFO-queue reference model; covers skid, no-skid and 64-bit builds.
module tb_if_id_pipeline_skid;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    int checks = 0;
    int errors = 0;

    // skid build (default parameters)
    logic        iv, ir, fl, ov, ordy;
    logic [31:0] ii, pi, io, po;
    logic [4:0]  rs1, rs2, rd;
    logic [6:0]  op, f7;
    logic [2:0]  f3;
    logic [1:0]  occ;

    // single-entry build
    logic        iv0, ir0, fl0, ov0, ordy0;
    logic [31:0] ii0, pi0, io0, po0;
    logic [4:0]  rs1_0, rs2_0, rd_0;
    logic [6:0]  op0, f7_0;
    logic [2:0]  f3_0;
    logic [1:0]  occ0;

    // 64-bit PC build
    logic        iv64, ir64, fl64, ov64, ordy64;
    logic [31:0] ii64, io64;
    logic [63:0] pi64, po64;
    logic [4:0]  rs1_64, rs2_64, rd_64;
    logic [6:0]  op64, f7_64;
    logic [2:0]  f3_64;
    logic [1:0]  occ64;

    if_id_pipeline_skid dut (
        .Clk(clk), .Reset_n(rst_n), .In_Valid(iv), .In_Ready(ir),
        .Instruction_IF(ii), .PC_IF(pi), .Flush(fl), .Out_Valid(ov), .Out_Ready(ordy),
        .Instruction_ID(io), .PC_ID(po), .rs1_ID(rs1), .rs2_ID(rs2), .rd_ID(rd),
        .Opcode_ID(op), .Func3_ID(f3), .Func7_ID(f7), .Occupancy(occ));

    if_id_pipeline_skid #(.SKID_EN(1'b0)) dut0 (
        .Clk(clk), .Reset_n(rst_n), .In_Valid(iv0), .In_Ready(ir0),
        .Instruction_IF(ii0), .PC_IF(pi0), .Flush(fl0), .Out_Valid(ov0), .Out_Ready(ordy0),
        .Instruction_ID(io0), .PC_ID(po0), .rs1_ID(rs1_0), .rs2_ID(rs2_0), .rd_ID(rd_0),
        .Opcode_ID(op0), .Func3_ID(f3_0), .Func7_ID(f7_0), .Occupancy(occ0));

    if_id_pipeline_skid #(.XLEN(64), .RESET_PC(64'h0000_0000_8000_0000)) dut64 (
        .Clk(clk), .Reset_n(rst_n), .In_Valid(iv64), .In_Ready(ir64),
        .Instruction_IF(ii64), .PC_IF(pi64), .Flush(fl64), .Out_Valid(ov64), .Out_Ready(ordy64),
        .Instruction_ID(io64), .PC_ID(po64), .rs1_ID(rs1_64), .rs2_ID(rs2_64), .rd_ID(rd_64),
        .Opcode_ID(op64), .Func3_ID(f3_64), .Func7_ID(f7_64), .Occupancy(occ64));

    // Drive one cycle on the skid build; returns at the following falling edge.
    task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                         input logic r, input logic f);
        iv = v; ii = ins; pi = pc; ordy = r; fl = f;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({ov, occ, io, po} !== {1'b0, 2'd0, NOP, 32'h0}) begin
            errors++;
            $display("FAIL reset_state got v=%b occ=%0d ins=%h pc=%h", ov, occ, io, po);
        end
        checks++;
        if ({op, rs1, rs2, rd, f3, f7} !== {7'h13, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0}) begin
            errors++;
            $display("FAIL reset_fields got op=%h rs1=%0d rs2=%0d rd=%0d f3=%0d f7=%0d",
                     op, rs1, rs2, rd, f3, f7);
        end
        checks++;
        if (po64 !== 64'h0000_0000_8000_0000 || io64 !== NOP) begin
            errors++;
            $display("FAIL reset_pc64 got pc=%h ins=%h exp pc=0000000080000000", po64, io64);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (ir !== 1'b1 || ir0 !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready got %b/%b exp 1/1", ir, ir0);
        end
        @(negedge clk);
    endtask

    task automatic test_stream();
        drive(1'b1, 32'h0050_0093, 32'h0, 1'b1, 1'b0);
        checks++;
        if ({ov, io, rd, op, po} !== {1'b1, 32'h0050_0093, 5'd1, 7'h13, 32'h0}) begin
            errors++;
            $display("FAIL stream_first got v=%b ins=%h rd=%0d op=%h pc=%h", ov, io, rd, op, po);
        end
        drive(1'b1, 32'h0020_81B3, 32'h4, 1'b1, 1'b0);
        checks++;
        if ({io, rs1, rs2, rd, f7, po} !== {32'h0020_81B3, 5'd1, 5'd2, 5'd3, 7'd0, 32'h4}) begin
            errors++;
            $display("FAIL stream_second got ins=%h rs1=%0d rs2=%0d rd=%0d f7=%0d pc=%h",
                     io, rs1, rs2, rd, f7, po);
        end
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        checks++;
        if (ov !== 1'b0 || occ !== 2'd0) begin
            errors++;
            $display("FAIL stream_drain got v=%b occ=%0d exp 0/0", ov, occ);
        end
    endtask

    task automatic test_backpressure();
        drive(1'b1, 32'hAAAA_0013, 32'h100, 1'b0, 1'b0);
        checks++;
        if ({io, occ, ir} !== {32'hAAAA_0013, 2'd1, 1'b1}) begin
            errors++;
            $display("FAIL bp_a got ins=%h occ=%0d rdy=%b", io, occ, ir);
        end
        drive(1'b1, 32'hBBBB_0013, 32'h104, 1'b0, 1'b0);
        checks++;
        if ({io, occ, ir} !== {32'hAAAA_0013, 2'd2, 1'b0}) begin
            errors++;
            $display("FAIL bp_skid got ins=%h occ=%0d rdy=%b", io, occ, ir);
        end
        drive(1'b1, 32'hxxxx_xxxx, 32'h108, 1'b0, 1'b0);
        checks++;
        if ({io, po, occ} !== {32'hAAAA_0013, 32'h100, 2'd2}) begin
            errors++;
            $display("FAIL bp_x_hold got ins=%h pc=%h occ=%0d", io, po, occ);
        end
        drive(1'b1, 32'hCCCC_0013, 32'h10C, 1'b0, 1'b0);
        checks++;
        if ({io, occ, ir} !== {32'hAAAA_0013, 2'd2, 1'b0}) begin
            errors++;
            $display("FAIL bp_c_stall got ins=%h occ=%0d rdy=%b", io, occ, ir);
        end
        drive(1'b1, 32'hCCCC_0013, 32'h10C, 1'b1, 1'b0);
        checks++;
        if ({io, po, occ, ir} !== {32'hBBBB_0013, 32'h104, 2'd1, 1'b1}) begin
            errors++;
            $display("FAIL bp_b_out got ins=%h pc=%h occ=%0d rdy=%b", io, po, occ, ir);
        end
        drive(1'b1, 32'hCCCC_0013, 32'h10C, 1'b1, 1'b0);
        checks++;
        if ({ov, io, po} !== {1'b1, 32'hCCCC_0013, 32'h10C}) begin
            errors++;
            $display("FAIL bp_c_out got v=%b ins=%h pc=%h", ov, io, po);
        end
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        checks++;
        if (ov !== 1'b0) begin
            errors++;
            $display("FAIL bp_empty got v=%b exp 0", ov);
        end
    endtask

    task automatic test_flush();
        drive(1'b1, 32'h1111_0013, 32'h180, 1'b0, 1'b0);
        drive(1'b1, 32'h2222_0013, 32'h184, 1'b0, 1'b0);
        drive(1'b1, 32'hDDDD_0013, 32'h200, 1'b1, 1'b1);
        checks++;
        if ({ov, occ, io, po, ir} !== {1'b0, 2'd0, NOP, 32'h0, 1'b1}) begin
            errors++;
            $display("FAIL flush_skid got v=%b occ=%0d ins=%h pc=%h rdy=%b", ov, occ, io, po, ir);
        end
        checks++;
        if ({op, rs1, rs2, rd, f3, f7} !== {7'h13, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0}) begin
            errors++;
            $display("FAIL flush_fields got op=%h rs1=%0d rd=%0d", op, rs1, rd);
        end
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        checks++;
        if (ov !== 1'b0 || io !== NOP) begin
            errors++;
            $display("FAIL flush_discard got v=%b ins=%h", ov, io);
        end
        drive(1'b1, 32'hEEEE_0013, 32'h300, 1'b1, 1'b0);
        checks++;
        if ({ov, io, po} !== {1'b1, 32'hEEEE_0013, 32'h300}) begin
            errors++;
            $display("FAIL flush_resume got v=%b ins=%h pc=%h", ov, io, po);
        end
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b1);
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        checks++;
        if ({ov, occ, io, po} !== {1'b0, 2'd0, NOP, 32'h0}) begin
            errors++;
            $display("FAIL flush_empty got v=%b occ=%0d ins=%h pc=%h", ov, occ, io, po);
        end
        fl = 1'b0;
    endtask

    task automatic test_no_skid();
        logic [31:0] w;
        iv0 = 1'b1; ii0 = 32'h0010_0013; pi0 = 32'h10; ordy0 = 1'b0;
        #1;
        checks++;
        if (ir0 !== 1'b1) begin
            errors++;
            $display("FAIL noskid_empty_rdy got %b exp 1", ir0);
        end
        @(posedge clk);
        @(negedge clk);
        ii0 = 32'h0020_0013; pi0 = 32'h14;
        #1;
        checks++;
        if ({ov0, io0, ir0} !== {1'b1, 32'h0010_0013, 1'b0}) begin
            errors++;
            $display("FAIL noskid_stall got v=%b ins=%h rdy=%b exp rdy 0", ov0, io0, ir0);
        end
        ordy0 = 1'b1;
        #1;
        checks++;
        if (ir0 !== 1'b1) begin
            errors++;
            $display("FAIL noskid_comb_rdy got %b exp 1", ir0);
        end
        for (int k = 2; k < 6; k++) begin
            w = 32'h0000_0013 | (32'(k) << 20);
            ii0 = w; pi0 = 32'(k) * 32'h4;
            @(posedge clk);
            @(negedge clk);
            checks++;
            if ({ov0, io0, po0, occ0} !== {1'b1, w, 32'(k) * 32'h4, 2'd1}) begin
                errors++;
                $display("FAIL noskid_tput k=%0d got v=%b ins=%h pc=%h occ=%0d exp ins=%h",
                         k, ov0, io0, po0, occ0, w);
            end
        end
        iv0 = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (ov0 !== 1'b0) begin
            errors++;
            $display("FAIL noskid_drain got v=%b exp 0", ov0);
        end
    endtask

    task automatic test_xlen64();
        iv64 = 1'b1; ii64 = 32'h00A0_0113; pi64 = 64'hFFFF_FFFF_0000_1000; ordy64 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        iv64 = 1'b0;
        checks++;
        if ({ov64, io64, po64, rd_64} !== {1'b1, 32'h00A0_0113, 64'hFFFF_FFFF_0000_1000, 5'd2}) begin
            errors++;
            $display("FAIL pc64_pass got v=%b ins=%h pc=%h rd=%0d", ov64, io64, po64, rd_64);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    // Reference: ordered queue of accepted words; head is what the decoder sees.
    task automatic test_random();
        logic [63:0] q[$];
        logic        exp_nop;
        logic        v, r, f, infire, outfire;
        logic [31:0] w, p;
        logic [63:0] h;
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        exp_nop = 1'b1;
        for (int c = 0; c < 600; c++) begin
            checks++;
            if ({ov, occ, ir} !== {logic'(q.size() != 0), 2'(q.size()), logic'(q.size() < 2)}) begin
                errors++;
                $display("FAIL rnd_ctrl cyc=%0d got v=%b occ=%0d rdy=%b exp size=%0d",
                         c, ov, occ, ir, q.size());
            end
            if (q.size() != 0) begin
                h = q[0];
                checks++;
                if ({io, po, rs1, rs2, rd, op, f3, f7} !== {h[63:32], h[31:0], h[51:47], h[56:52],
                        h[43:39], h[38:32], h[46:44], h[63:57]}) begin
                    errors++;
                    $display("FAIL rnd_data cyc=%0d got ins=%h pc=%h exp ins=%h pc=%h",
                             c, io, po, h[63:32], h[31:0]);
                end
            end else if (exp_nop) begin
                checks++;
                if ({io, po, op} !== {NOP, 32'h0, 7'h13}) begin
                    errors++;
                    $display("FAIL rnd_nop cyc=%0d got ins=%h pc=%h", c, io, po);
                end
            end
            v = ($urandom_range(3) != 0);
            r = $urandom_range(1) == 1;
            f = ($urandom_range(19) == 0);
            w = $urandom;
            p = {$urandom_range(16'hFFFF, 0), 2'b00};
            infire  = v && (q.size() < 2);
            outfire = (q.size() != 0) && r;
            if (f) begin
                q.delete();
                exp_nop = 1'b1;
            end else begin
                if (outfire) void'(q.pop_front());
                if (infire) begin
                    q.push_back({w, p});
                    exp_nop = 1'b0;
                end
            end
            drive(v, v ? w : 32'hxxxx_xxxx, p, r, f);
        end
        fl = 1'b0;
    endtask

    task automatic test_reset_midstall();
        drive(1'b1, 32'h3333_0013, 32'h400, 1'b0, 1'b0);
        drive(1'b1, 32'h4444_0013, 32'h404, 1'b0, 1'b0);
        drive(1'b1, 32'h5555_0013, 32'h404, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({ov, occ, io, po, ir} !== {1'b0, 2'd0, NOP, 32'h0, 1'b1}) begin
            errors++;
            $display("FAIL reset_skid got v=%b occ=%0d ins=%h pc=%h rdy=%b", ov, occ, io, po, ir);
        end
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        checks++;
        if ({ov, ir, occ} !== {1'b0, 1'b1, 2'd0}) begin
            errors++;
            $display("FAIL reset_release got v=%b rdy=%b occ=%0d", ov, ir, occ);
        end
    endtask

    initial begin
        iv = 1'b0; ii = '0; pi = '0; ordy = 1'b0; fl = 1'b0;
        iv0 = 1'b0; ii0 = '0; pi0 = '0; ordy0 = 1'b0; fl0 = 1'b0;
        iv64 = 1'b0; ii64 = '0; pi64 = '0; ordy64 = 1'b0; fl64 = 1'b0;
        test_reset();
        test_stream();
        test_backpressure();
        test_flush();
        test_no_skid();
        test_xlen64();
        test_random();
        test_reset_midstall();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/if_id_pipeline_skid.md
Name: if_id_pipeline_skid

Overview:
Parametrised IF/ID pipeline register with valid/ready handshaking, a 2-entry skid buffer for back-pressure, and synchronous flush for branch redirect. It sits between the fetch unit/program memory and the decoder. It decodes rs1/rs2/rd/opcode/func3/func7 fields at capture, and its outputs stay stable while the decoder stalls.

Parameters:
XLEN, 32, width of PC_IF/PC_ID.
RESET_PC, 32'h00000000, PC_ID value after reset or flush.
NOP_INSTR, 32'h00000013, instruction held after reset or flush (addi x0,x0,0).
SKID_EN, 1, 1 = 2-entry skid with registered In_Ready; 0 = single entry with combinational In_Ready.

Ports:
Clk  input  1  rising-edge clock
Reset_n  input  1  asynchronous, active-low reset
In_Valid  input  1  fetch presents an instruction
In_Ready  output  1  stage can accept
Instruction_IF  input  32  fetched instruction word
PC_IF  input  XLEN  PC of the fetched instruction
Flush  input  1  synchronous kill of all held entries
Out_Valid  output  1  ID outputs hold a live instruction
Out_Ready  input  1  decoder consumes this cycle
Instruction_ID  output  32  held instruction
PC_ID  output  XLEN  held PC
rs1_ID  output  5  Instruction_ID[19:15]
rs2_ID  output  5  Instruction_ID[24:20]
rd_ID  output  5  Instruction_ID[11:7]
Opcode_ID  output  7  Instruction_ID[6:0]
Func3_ID  output  3  Instruction_ID[14:12]
Func7_ID  output  7  Instruction_ID[31:25]
Occupancy  output  2  live entries, 0..2

Behaviour:
- Single clock Clk; reset is asynchronous and active-low (Reset_n). All state clears immediately on Reset_n=0.
- Reset and flush values:
  - Out_Valid=0, Occupancy=0.
  - Instruction_ID=NOP_INSTR, PC_ID=RESET_PC.
  - Decoded fields equal the decode of NOP_INSTR. For the default: Opcode_ID=7'b0010011, all other fields 0.
  - Skid entry is invalidated.
- Handshake terms:
  - in_fire = In_Valid & In_Ready.
  - out_fire = Out_Valid & Out_Ready.
  - Data is captured only on in_fire. Outputs hold while Out_Valid=1 and Out_Ready=0.
- Latency: 1 cycle. An instruction accepted at edge N appears on the outputs with Out_Valid=1 after edge N when the stage was empty or drained at N.
- State machine (SKID_EN=1), main = output register, skid = overflow register:
  - EMPTY: in_fire -> main<=in, go FULL.
  - FULL:
    - in_fire & out_fire -> main<=in, stay FULL.
    - in_fire & !out_fire -> skid<=in, go SKID.
    - !in_fire & out_fire -> go EMPTY.
  - SKID: out_fire -> main<=skid, go FULL.
- In_Ready (SKID_EN=1) = (state!=SKID), registered; it has no combinational path from Out_Ready.
- In_Ready (SKID_EN=0) = !Out_Valid | Out_Ready; the SKID state is unreachable.
- Occupancy: EMPTY=0, FULL=1, SKID=2.
- Program order is strictly preserved. No entry is dropped or duplicated.
- Decoded fields are registered together with Instruction_ID. They never come from a combinational decode of the input.
- Flush has priority over a simultaneous in_fire and out_fire:
  - Next state is EMPTY, the input is discarded, and outputs take their NOP values.
  - The out_fire in the flush cycle still counts as consumed by the decoder.
- Flush while EMPTY is harmless and leaves outputs at their NOP values.
- Reset asserted mid-stall or in SKID: all entries are lost immediately. After Reset_n rises, In_Ready is 1 on the first clock.
- Data is ignored whenever In_Valid=0. X on Instruction_IF must not propagate while In_Ready=0.

Test Plan:
- Reset with Reset_n=0 mid-cycle (async) -> immediately Out_Valid=0, Instruction_ID=0x00000013, PC_ID=0, Opcode_ID=0x13, Occupancy=0, In_Ready=1 after release.
- Stream with Out_Ready=1: inputs 0x00500093 (PC 0x0), 0x002081B3 (PC 0x4) -> after 1 cycle Instruction_ID=0x00500093, rd_ID=1, Opcode_ID=0x13. Next cycle 0x002081B3 with rs1=1, rs2=2, rd=3, Func7=0, PC_ID=0x4.
- Back-pressure: hold Out_Ready=0 and offer 3 instructions A, B, C -> A held, B in skid, Occupancy=2, In_Ready=0 so C is stalled. Raise Out_Ready -> A, B, C emerge in order with no loss.
- Flush in SKID state together with In_Valid=1 -> next cycle Out_Valid=0, Occupancy=0, Instruction_ID=NOP, PC_ID=RESET_PC, and the flushed-cycle input never appears.
- SKID_EN=0 build: Out_Valid=1, Out_Ready=0 -> In_Ready=0 in the same cycle. With Out_Ready=1 -> In_Ready=1 combinationally and throughput is 1 instruction per cycle.
- XLEN=64, RESET_PC=0x80000000: reset -> PC_ID=0x0000000080000000. Input PC 0xFFFFFFFF00001000 passes unchanged.
